// File: rtl/sm83_alu_if.sv
// Request/response bundle between the sequencer and the slice-serial SM83 ALU.
// The master issues operations and flag loads; the slave returns result, flags and status.
interface sm83_alu_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flag_ld;
    logic [3:0]       flags_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] res;
    logic [3:0]       flags;

    modport master (
        output start, op, a, b, flag_ld, flags_in,
        input  busy, done, res, flags
    );

    modport slave (
        input  start, op, a, b, flag_ld, flags_in,
        output busy, done, res, flags
    );
endinterface

// File: rtl/sm83_alu_seq.sv
// Slice-serial SM83 ALU: arithmetic/logic ops run SLICE bits per beat with a chained carry;
// rotates, shifts and DAA finish in one cycle. Flags {Z,N,H,C} are registered.
module sm83_alu_seq #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SLICE = 4
) (
    input logic       CLK,
    input logic       RESET,
    sm83_alu_if.slave bus
);
    localparam int unsigned BEATS = WIDTH / SLICE;
    localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned HBEAT = 3 / SLICE;
    localparam int unsigned HBIT  = 3 % SLICE;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e           state_q;
    logic [BW-1:0]    beat_q;
    logic [WIDTH-1:0] a_q, b_q, res_q;
    logic [2:0]       op_q;
    logic             cy_q, zero_q, h_q, busy_q, done_q;
    logic [3:0]       flags_q;

    // Slice datapath for the running op
    logic [SLICE-1:0] sa, sb, sum, slice;
    logic             c, h_n, zero_n, is_sub;
    logic [WIDTH-1:0] res_n;
    logic [3:0]       rflags;

    always_comb begin
        is_sub = (op_q == 3'd2) || (op_q == 3'd3) || (op_q == 3'd7);
        sa     = a_q[SLICE-1:0];
        sb     = is_sub ? ~b_q[SLICE-1:0] : b_q[SLICE-1:0];
        c      = cy_q;
        h_n    = h_q;
        sum    = '0;
        for (int j = 0; j < int'(SLICE); j++) begin
            sum[j] = sa[j] ^ sb[j] ^ c;
            c      = (sa[j] & sb[j]) | (c & (sa[j] ^ sb[j]));
            if (beat_q == BW'(HBEAT) && j == int'(HBIT)) h_n = c;
        end
        unique case (op_q)
            3'd4:    slice = sa & b_q[SLICE-1:0];
            3'd5:    slice = sa ^ b_q[SLICE-1:0];
            3'd6:    slice = sa | b_q[SLICE-1:0];
            default: slice = sum;
        endcase
        zero_n = zero_q & (slice == '0);
        res_n  = res_q;
        if (op_q != 3'd7) begin
            for (int i = 0; i < int'(BEATS); i++) begin
                if (beat_q == BW'(i)) res_n[i*SLICE +: SLICE] = slice;
            end
        end
        unique case (op_q)
            3'd4:             rflags = {zero_n, 1'b0, 1'b1, 1'b0};
            3'd5, 3'd6:       rflags = {zero_n, 3'b000};
            3'd2, 3'd3, 3'd7: rflags = {zero_n, 1'b1, ~h_n, ~c};
            default:          rflags = {zero_n, 1'b0, h_n, c};
        endcase
    end

    // Single-cycle ops and carry-in selection, evaluated on the issue cycle
    logic [3:0]       fl_eff;
    logic             cin_eff, cin0, sc;
    logic [WIDTH-1:0] sres;
    logic [7:0]       lo, corr;
    logic [3:0]       sflags;

    always_comb begin
        fl_eff  = bus.flag_ld ? bus.flags_in : flags_q;
        cin_eff = fl_eff[0];
        unique case (bus.op[2:0])
            3'd1:       cin0 = cin_eff;
            3'd2, 3'd7: cin0 = 1'b1;
            3'd3:       cin0 = ~cin_eff;
            default:    cin0 = 1'b0;
        endcase
        sres = bus.a;
        sc   = 1'b0;
        lo   = bus.a[7:0];
        corr = 8'h00;
        unique case (bus.op)
            4'd8:  begin sres = {bus.a[WIDTH-2:0], bus.a[WIDTH-1]}; sc = bus.a[WIDTH-1]; end
            4'd9:  begin sres = {bus.a[0], bus.a[WIDTH-1:1]};       sc = bus.a[0];       end
            4'd10: begin sres = {bus.a[WIDTH-2:0], cin_eff};        sc = bus.a[WIDTH-1]; end
            4'd11: begin sres = {cin_eff, bus.a[WIDTH-1:1]};        sc = bus.a[0];       end
            4'd12: begin sres = {bus.a[WIDTH-2:0], 1'b0};           sc = bus.a[WIDTH-1]; end
            4'd13: begin sres = {bus.a[WIDTH-1], bus.a[WIDTH-1:1]}; sc = bus.a[0];       end
            4'd15: begin sres = {1'b0, bus.a[WIDTH-1:1]};           sc = bus.a[0];       end
            4'd14: begin
                sc = fl_eff[0];
                if (!fl_eff[2]) begin
                    if (fl_eff[0] || lo > 8'h99) begin
                        corr = corr | 8'h60;
                        sc   = 1'b1;
                    end
                    if (fl_eff[1] || lo[3:0] > 4'h9) corr = corr | 8'h06;
                    lo = lo + corr;
                end else begin
                    if (fl_eff[0]) corr = corr | 8'h60;
                    if (fl_eff[1]) corr = corr | 8'h06;
                    lo = lo - corr;
                end
                sres[7:0] = lo;
            end
            default: sres = bus.a;
        endcase
        sflags = {sres == '0, (bus.op == 4'd14) ? fl_eff[2] : 1'b0, 1'b0, sc};
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= StIdle;
            beat_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            cy_q    <= 1'b0;
            zero_q  <= 1'b0;
            h_q     <= 1'b0;
            res_q   <= '0;
            flags_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.flag_ld) flags_q <= bus.flags_in;
                    if (bus.start) begin
                        if (bus.op[3]) begin
                            res_q   <= sres;
                            flags_q <= sflags;
                            done_q  <= 1'b1;
                        end else begin
                            // res starts as a so CP can leave it untouched
                            a_q     <= bus.a;
                            b_q     <= bus.b;
                            op_q    <= bus.op[2:0];
                            cy_q    <= cin0;
                            zero_q  <= 1'b1;
                            h_q     <= 1'b0;
                            beat_q  <= '0;
                            res_q   <= bus.a;
                            busy_q  <= 1'b1;
                            state_q <= StRun;
                        end
                    end
                end
                StRun: begin
                    a_q    <= a_q >> SLICE;
                    b_q    <= b_q >> SLICE;
                    cy_q   <= c;
                    zero_q <= zero_n;
                    h_q    <= h_n;
                    res_q  <= res_n;
                    beat_q <= beat_q + BW'(1);
                    if (beat_q == BW'(BEATS - 1)) begin
                        flags_q <= rflags;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.res   = res_q;
    assign bus.flags = flags_q;
endmodule

// File: tb/tb_sm83_alu_seq.sv
// Scoreboard bench: an 8-bit/4-slice and a 16-bit/4-slice instance driven with directed vectors.
module tb_sm83_alu_seq;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sm83_alu_if #(.WIDTH(8))  b8 ();
    sm83_alu_if #(.WIDTH(16)) b16 ();

    sm83_alu_seq #(.WIDTH(8), .SLICE(4)) dut8 (
        .CLK   (clk),
        .RESET (rst),
        .bus   (b8)
    );
    sm83_alu_seq #(.WIDTH(16), .SLICE(4)) dut16 (
        .CLK   (clk),
        .RESET (rst),
        .bus   (b16)
    );

    typedef struct {
        logic [15:0] res;
        logic [3:0]  flags;
        string       name;
    } exp_t;

    exp_t q8[$];
    exp_t q16[$];
    int   nvec = 0;
    int   nerr = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitors: compare on every done pulse
    always @(negedge clk) begin
        exp_t e;
        if (b8.done === 1'b1) begin
            if (q8.size() == 0) begin
                chk("done8_unexpected", 16'(b8.done), 16'd0);
            end else begin
                e = q8.pop_front();
                chk({e.name, "_res"}, 16'(b8.res), e.res);
                chk({e.name, "_flags"}, 16'(b8.flags), 16'(e.flags));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (b16.done === 1'b1) begin
            if (q16.size() == 0) begin
                chk("done16_unexpected", 16'(b16.done), 16'd0);
            end else begin
                e = q16.pop_front();
                chk({e.name, "_res"}, b16.res, e.res);
                chk({e.name, "_flags"}, 16'(b16.flags), 16'(e.flags));
            end
        end
    end

    task automatic issue8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic fl, input logic [3:0] fin, input bit push,
                          input string nm, input logic [7:0] eres, input logic [3:0] efl);
        exp_t e;
        if (push) begin
            e.res = 16'(eres); e.flags = efl; e.name = nm;
            q8.push_back(e);
        end
        b8.op = op; b8.a = a; b8.b = b; b8.flag_ld = fl; b8.flags_in = fin; b8.start = 1'b1;
        @(posedge clk); #1;
        b8.start = 1'b0; b8.flag_ld = 1'b0;
    endtask

    task automatic issue16(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                           input logic fl, input logic [3:0] fin,
                           input string nm, input logic [15:0] eres, input logic [3:0] efl);
        exp_t e;
        e.res = eres; e.flags = efl; e.name = nm;
        q16.push_back(e);
        b16.op = op; b16.a = a; b16.b = b; b16.flag_ld = fl; b16.flags_in = fin;
        b16.start = 1'b1;
        @(posedge clk); #1;
        b16.start = 1'b0; b16.flag_ld = 1'b0;
    endtask

    task automatic wait_done(input int which, input string nm);
        bit got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            got = (which == 8) ? b8.done : b16.done;
        end
        chk({nm, "_timeout"}, 16'(got), 16'd1);
    endtask

    // Busy for nbusy cycles after the start edge, then done with busy low
    task automatic timed8(input int nbusy, input string nm);
        for (int k = 0; k < nbusy; k++) begin
            @(negedge clk);
            chk({nm, "_busy"}, 16'(b8.busy), 16'd1);
            chk({nm, "_nodone"}, 16'(b8.done), 16'd0);
        end
        @(negedge clk);
        chk({nm, "_done"}, 16'(b8.done), 16'd1);
        chk({nm, "_idle"}, 16'(b8.busy), 16'd0);
    endtask

    task automatic summary();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    endtask

    initial begin
        #100000;
        chk("watchdog", 16'd1, 16'd0);
        summary();
    end

    initial begin
        rst = 1'b1;
        b8.start = 0; b8.op = 0; b8.a = 0; b8.b = 0; b8.flag_ld = 0; b8.flags_in = 0;
        b16.start = 0; b16.op = 0; b16.a = 0; b16.b = 0; b16.flag_ld = 0; b16.flags_in = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy8", 16'(b8.busy), 16'd0);
        chk("rst_done8", 16'(b8.done), 16'd0);
        chk("rst_res8", 16'(b8.res), 16'd0);
        chk("rst_flags8", 16'(b8.flags), 16'd0);
        chk("rst_busy16", 16'(b16.busy), 16'd0);
        chk("rst_res16", b16.res, 16'd0);
        chk("rst_flags16", 16'(b16.flags), 16'd0);

        // 8-bit arithmetic / logic
        issue8(4'd0, 8'h3A, 8'hC6, 0, 4'h0, 1, "add_3a_c6", 8'h00, 4'b1011);
        timed8(2, "add_timing");
        issue8(4'd2, 8'h3E, 8'h3F, 0, 4'h0, 1, "sub_3e_3f", 8'hFF, 4'b0111);
        wait_done(8, "sub");
        issue8(4'd7, 8'h3C, 8'h3C, 0, 4'h0, 1, "cp_3c", 8'h3C, 4'b1100);
        wait_done(8, "cp");
        issue8(4'd0, 8'h15, 8'h27, 0, 4'h0, 1, "add_15_27", 8'h3C, 4'b0000);
        wait_done(8, "add2");
        issue8(4'd14, 8'h3C, 8'h00, 0, 4'h0, 1, "daa_3c", 8'h42, 4'b0000);
        timed8(0, "daa_timing");
        issue8(4'd4, 8'hF0, 8'h0F, 0, 4'h0, 1, "and", 8'h00, 4'b1010);
        wait_done(8, "and");
        issue8(4'd5, 8'hFF, 8'h0F, 0, 4'h0, 1, "xor", 8'hF0, 4'b0000);
        wait_done(8, "xor");
        issue8(4'd6, 8'h50, 8'h0A, 0, 4'h0, 1, "or", 8'h5A, 4'b0000);
        wait_done(8, "or");
        issue8(4'd3, 8'h10, 8'h01, 1, 4'b0001, 1, "sbc", 8'h0E, 4'b0110);
        wait_done(8, "sbc");
        issue8(4'd14, 8'h0F, 8'h00, 1, 4'b0110, 1, "daa_n", 8'h09, 4'b0100);
        wait_done(8, "daa_n");
        issue8(4'd14, 8'h00, 8'h00, 1, 4'b0001, 1, "daa_c", 8'h60, 4'b0001);
        wait_done(8, "daa_c");

        // rotates and shifts
        issue8(4'd10, 8'h80, 8'h00, 1, 4'b0000, 1, "rl_80", 8'h00, 4'b1001);
        wait_done(8, "rl");
        issue8(4'd11, 8'h01, 8'h00, 0, 4'h0, 1, "rr_01", 8'h80, 4'b0001);
        wait_done(8, "rr");
        issue8(4'd8, 8'h85, 8'h00, 0, 4'h0, 1, "rlc_85", 8'h0B, 4'b0001);
        wait_done(8, "rlc");
        issue8(4'd9, 8'h01, 8'h00, 0, 4'h0, 1, "rrc_01", 8'h80, 4'b0001);
        wait_done(8, "rrc");
        issue8(4'd12, 8'h80, 8'h00, 0, 4'h0, 1, "sla_80", 8'h00, 4'b1001);
        wait_done(8, "sla");
        issue8(4'd13, 8'h81, 8'h00, 0, 4'h0, 1, "sra_81", 8'hC0, 4'b0001);
        wait_done(8, "sra");
        issue8(4'd15, 8'h01, 8'h00, 0, 4'h0, 1, "srl_01", 8'h00, 4'b1001);
        wait_done(8, "srl");
        issue8(4'd1, 8'h01, 8'h01, 0, 4'h0, 1, "adc_c1", 8'h03, 4'b0000);
        wait_done(8, "adc");

        // flag load while idle
        @(posedge clk); #1;
        b8.flag_ld = 1'b1; b8.flags_in = 4'b1010;
        @(posedge clk); #1;
        b8.flag_ld = 1'b0;
        @(negedge clk);
        chk("flag_ld_idle", 16'(b8.flags), 16'(4'b1010));

        // 16-bit: ADC with loaded carry; a start during busy must be dropped
        issue16(4'd1, 16'hFFFF, 16'h0000, 1, 4'b0001, "adc16", 16'h0000, 4'b1011);
        @(negedge clk);
        chk("adc16_busy1", 16'(b16.busy), 16'd1);
        b16.start = 1'b1; b16.op = 4'd0; b16.a = 16'h0001; b16.b = 16'h0001;
        @(negedge clk);
        chk("adc16_busy2", 16'(b16.busy), 16'd1);
        b16.start = 1'b0;
        @(negedge clk);
        chk("adc16_busy3", 16'(b16.busy), 16'd1);
        @(negedge clk);
        chk("adc16_busy4", 16'(b16.busy), 16'd1);
        chk("adc16_nodone4", 16'(b16.done), 16'd0);
        @(negedge clk);
        chk("adc16_done", 16'(b16.done), 16'd1);
        chk("adc16_idle", 16'(b16.busy), 16'd0);
        @(negedge clk);
        chk("adc16_pulse", 16'(b16.done), 16'd0);
        issue16(4'd0, 16'h0FFF, 16'h0001, 0, 4'h0, "add16", 16'h1000, 4'b0010);
        wait_done(16, "add16");
        issue16(4'd14, 16'hAB3C, 16'h0000, 1, 4'b0000, "daa16", 16'hAB42, 4'b0000);
        wait_done(16, "daa16");
        issue16(4'd2, 16'h1000, 16'h0001, 0, 4'h0, "sub16", 16'h0FFF, 4'b0110);
        wait_done(16, "sub16");

        // reset during beat 1 aborts the op
        issue8(4'd0, 8'h3A, 8'hC6, 0, 4'h0, 0, "abort", 8'h00, 4'h0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", 16'(b8.busy), 16'd0);
        chk("abort_done", 16'(b8.done), 16'd0);
        chk("abort_res", 16'(b8.res), 16'd0);
        chk("abort_flags", 16'(b8.flags), 16'd0);
        issue8(4'd0, 8'h01, 8'h01, 0, 4'h0, 1, "add_after_rst", 8'h02, 4'b0000);
        wait_done(8, "add_after_rst");

        repeat (4) @(negedge clk);
        chk("q8_drained", 16'(q8.size()), 16'd0);
        chk("q16_drained", 16'(q16.size()), 16'd0);
        summary();
    end
endmodule
